// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, state enum and helpers for the memory stage
//
// Purpose : memOp / funct3 encodings, FSM state type, default width and
//           small combinational helpers used by mem_access_stage.
// Ports   : none (package).
package mem_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] MEMOP_NONE  = 2'b00;
  localparam logic [1:0] MEMOP_LOAD  = 2'b01;
  localparam logic [1:0] MEMOP_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Byte enables for a store; anything that is not a byte or half is a word.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    store_mask = 4'b0001 << a;
      F3_H:    store_mask = 4'b0011 << {a[1], 1'b0};
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // Halfwords need a[0]=0; words (and undefined sizes, which act as words)
  // need a[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: is_misaligned = 1'b0;
      F3_H, F3_HU: is_misaligned = a[0];
      default:     is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed lane of a loaded word
//
// Purpose : combinational load data alignment and sign/zero extension.
// Ports   : rdata  in  XLEN  loaded word
//           addr   in  2     low byte-address bits
//           funct3 in  3     size/sign (B/H/W/BU/HU, others act as W)
//           data   out XLEN  aligned, extended result
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  // Halfwords only look at addr[1]; an odd address is never split.
  assign byte_sh = rdata >> {addr, 3'b000};
  assign half_sh = rdata >> {addr[1], 4'b0000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      F3_H:    data = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage with single-outstanding dmem port
//
// Purpose : accepts one instruction from EX, runs its load/store on the
//           req/gnt/rvalid data port, and emits one registered writeback
//           record per instruction to WB.
// Ports   : clk, rst (async, active-low)
//           in_valid/in_ready, in_pc, alu, rd2, memOp, funct3, we, wa  from EX
//           dmem_req/we/addr/wmask/wdata, dmem_gnt/rvalid/rdata        memory
//           out_valid/we/wa/wd/pc/misalign                             to WB
// Option  : MEM_MISALIGN_TRAP_EN - misaligned H/W accesses skip memory and
//           return a record flagged out_misalign.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int          XLEN       = XLEN_DEFAULT,
  parameter logic [31:0] RST_OUT_PC = 32'h0000_0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] rd2,
  input  logic [1:0]      memOp,
  input  logic [2:0]      funct3,
  input  logic            we,
  input  logic [4:0]      wa,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            out_valid,
  output logic            out_we,
  output logic [4:0]      out_wa,
  output logic [XLEN-1:0] out_wd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_misalign
);

  mem_state_t      state;
  logic            is_store_r;
  logic [2:0]      f3_r;
  logic [1:0]      addr_lo_r;
  logic            we_r;
  logic [4:0]      wa_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] load_data;
  logic            is_mem;
  logic [XLEN-1:0] st_data;

  assign in_ready = (state == IDLE);
  // Reserved encoding 11 falls through as a non-memory instruction.
  assign is_mem   = (memOp == MEMOP_LOAD) || (memOp == MEMOP_STORE);

  always_comb begin
    st_data = rd2;
    case (funct3)
      F3_B:    st_data = {(XLEN/8){rd2[7:0]}};
      F3_H:    st_data = {(XLEN/16){rd2[15:0]}};
      default: st_data = rd2;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .addr   (addr_lo_r),
    .funct3 (f3_r),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      is_store_r   <= 1'b0;
      f3_r         <= '0;
      addr_lo_r    <= '0;
      we_r         <= 1'b0;
      wa_r         <= '0;
      pc_r         <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wmask   <= '0;
      dmem_wdata   <= '0;
      out_valid    <= 1'b0;
      out_we       <= 1'b0;
      out_wa       <= '0;
      out_wd       <= '0;
      out_pc       <= XLEN'(RST_OUT_PC);
      out_misalign <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              out_valid    <= 1'b1;
              out_we       <= we;
              out_wa       <= wa;
              out_wd       <= alu;
              out_pc       <= in_pc;
              out_misalign <= 1'b0;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (is_misaligned(funct3, alu[1:0])) begin
              out_valid    <= 1'b1;
              out_we       <= 1'b0;
              out_pc       <= in_pc;
              out_misalign <= 1'b1;
            end
`endif
            else begin
              is_store_r <= (memOp == MEMOP_STORE);
              f3_r       <= funct3;
              addr_lo_r  <= alu[1:0];
              // Stores never write the register file.
              we_r       <= we && (memOp == MEMOP_LOAD);
              wa_r       <= wa;
              pc_r       <= in_pc;
              dmem_req   <= 1'b1;
              dmem_we    <= (memOp == MEMOP_STORE);
              dmem_addr  <= {alu[XLEN-1:2], 2'b00};
              dmem_wmask <= (memOp == MEMOP_STORE) ? store_mask(funct3, alu[1:0]) : 4'b0000;
              dmem_wdata <= (memOp == MEMOP_STORE) ? st_data : '0;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          // Without a grant every dmem output simply holds.
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (is_store_r) begin
              out_valid    <= 1'b1;
              out_we       <= 1'b0;
              out_wa       <= wa_r;
              out_pc       <= pc_r;
              out_misalign <= 1'b0;
              state        <= IDLE;
            end else if (dmem_rvalid) begin
              out_valid    <= 1'b1;
              out_we       <= we_r;
              out_wa       <= wa_r;
              out_wd       <= load_data;
              out_pc       <= pc_r;
              out_misalign <= 1'b0;
              state        <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            out_valid    <= 1'b1;
            out_we       <= we_r;
            out_wa       <= wa_r;
            out_wd       <= load_data;
            out_pc       <= pc_r;
            out_misalign <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, alu, rd2;
  logic [1:0]  memOp;
  logic [2:0]  funct3;
  logic        we;
  logic [4:0]  wa;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid, out_we, out_misalign;
  logic [4:0]  out_wa;
  logic [31:0] out_wd, out_pc;

  logic [31:0] ref_rdata;
  logic [1:0]  ref_addr;
  logic [2:0]  ref_f3;
  logic [31:0] ref_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .alu(alu), .rd2(rd2),
    .memOp(memOp), .funct3(funct3), .we(we), .wa(wa),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_we(out_we), .out_wa(out_wa), .out_wd(out_wd),
    .out_pc(out_pc), .out_misalign(out_misalign)
  );

  load_align u_ref (.rdata(ref_rdata), .addr(ref_addr), .funct3(ref_f3), .data(ref_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic w, input logic [4:0] r,
                       input logic [31:0] pc);
    in_valid = 1'b1; memOp = op; funct3 = f3; alu = a; rd2 = d; we = w; wa = r; in_pc = pc;
    step();
    in_valid = 1'b0; memOp = MEMOP_NONE;
  endtask

  // Load granted, one idle cycle, then data two cycles after the grant.
  task automatic slow_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                           input logic [31:0] exp, input string tag);
    issue(MEMOP_LOAD, f3, a, 32'h0, 1'b1, 5'd9, 32'h50);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, 32'h100);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    step();
    chk({tag, "_wait_nv"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_wait_rdy"}, {31'd0, in_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    step();
    dmem_rvalid = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_wd"}, out_wd, exp);
    chk({tag, "_we"}, {31'd0, out_we}, 32'd1);
    chk({tag, "_pc"}, out_pc, 32'h50);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; alu = '0; rd2 = '0; memOp = '0; funct3 = '0;
    we = 1'b0; wa = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    ref_rdata = '0; ref_addr = '0; ref_f3 = '0;
    step(); step();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h1);
    chk("rst_wd", out_wd, 32'h0);
    chk("rst_misalign", {31'd0, out_misalign}, 32'd0);
    rst = 1'b1;
    step();

    // Non-memory pass-through, back to back.
    in_valid = 1'b1; memOp = MEMOP_NONE; alu = 32'h1234; we = 1'b1; wa = 5'd5; in_pc = 32'h40;
    #1 chk("alu_ready_pre", {31'd0, in_ready}, 32'd1);
    step();
    chk("alu_valid", {31'd0, out_valid}, 32'd1);
    chk("alu_wd", out_wd, 32'h1234);
    chk("alu_wa", {27'd0, out_wa}, 32'd5);
    chk("alu_pc", out_pc, 32'h40);
    chk("alu_ready", {31'd0, in_ready}, 32'd1);
    alu = 32'h55; wa = 5'd6; in_pc = 32'h44; memOp = 2'b11;
    step();
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_wd", out_wd, 32'h55);
    in_valid = 1'b0;
    step();
    chk("idle_nv", {31'd0, out_valid}, 32'd0);
    chk("idle_hold", out_wd, 32'h55);

    // SB with grant held off three cycles.
    issue(MEMOP_STORE, F3_B, 32'h103, 32'hAB, 1'b1, 5'd7, 32'h48);
    for (int i = 0; i < 3; i++) begin
      chk("sb_req", {31'd0, dmem_req}, 32'd1);
      chk("sb_we", {31'd0, dmem_we}, 32'd1);
      chk("sb_addr", dmem_addr, 32'h100);
      chk("sb_mask", {28'd0, dmem_wmask}, 32'b1000);
      chk("sb_wdata", dmem_wdata, 32'hABABABAB);
      chk("sb_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("sb_hold_nv", {31'd0, out_valid}, 32'd0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("sb_done", {31'd0, out_valid}, 32'd1);
    chk("sb_out_we", {31'd0, out_we}, 32'd0);
    chk("sb_req_drop", {31'd0, dmem_req}, 32'd0);
    step();
    chk("sb_pulse", {31'd0, out_valid}, 32'd0);

    // SH lanes and halfword replication.
    issue(MEMOP_STORE, F3_H, 32'h2, 32'h1234_5678, 1'b0, 5'd0, 32'h4C);
    chk("sh_mask", {28'd0, dmem_wmask}, 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'h56785678);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;

    slow_load(F3_B, 32'h102, 32'h0080_0000, 32'hFFFF_FF80, "lb");
    slow_load(F3_BU, 32'h102, 32'h0080_0000, 32'h0000_0080, "lbu");

    // LH with grant and data in the same cycle.
    issue(MEMOP_LOAD, F3_H, 32'h2, 32'h0, 1'b1, 5'd8, 32'h58);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("lh_valid", {31'd0, out_valid}, 32'd1);
    chk("lh_wd", out_wd, 32'hFFFF_8001);
    chk("lh_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("lh_once", {31'd0, out_valid}, 32'd0);

    // Reset while waiting for data; late rvalid must be ignored.
    issue(MEMOP_LOAD, F3_W, 32'h200, 32'h0, 1'b1, 5'd3, 32'h5C);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("rw_wait", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rw_async_ready", {31'd0, in_ready}, 32'd1);
    chk("rw_async_req", {31'd0, dmem_req}, 32'd0);
    step();
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_rvalid = 1'b0;
    chk("rw_no_rec", {31'd0, out_valid}, 32'd0);
    chk("rw_idle", {31'd0, in_ready}, 32'd1);
    chk("rw_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_pc", out_pc, 32'h1);

    // Misaligned LW.
    issue(MEMOP_LOAD, F3_W, 32'h6, 32'h0, 1'b1, 5'd4, 32'h60);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_we", {31'd0, out_we}, 32'd0);
    chk("mis_flag", {31'd0, out_misalign}, 32'd1);
    chk("mis_pc", out_pc, 32'h60);
    chk("mis_ready", {31'd0, in_ready}, 32'd1);
`else
    chk("mis_req", {31'd0, dmem_req}, 32'd1);
    chk("mis_addr", dmem_addr, 32'h4);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_BABE;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("mis_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_wd", out_wd, 32'hCAFE_BABE);
    chk("mis_flag", {31'd0, out_misalign}, 32'd0);
`endif

    // Alignment helper on its own: lanes, extension, odd halfword, undefined size.
    ref_rdata = 32'h8899_AABB;
    ref_addr = 2'd1; ref_f3 = F3_BU; #1 chk("la_bu1", ref_data, 32'h0000_00AA);
    ref_addr = 2'd3; ref_f3 = F3_B;  #1 chk("la_b3", ref_data, 32'hFFFF_FF88);
    ref_addr = 2'd2; ref_f3 = F3_HU; #1 chk("la_hu2", ref_data, 32'h0000_8899);
    ref_addr = 2'd0; ref_f3 = F3_H;  #1 chk("la_h0", ref_data, 32'hFFFF_AABB);
    ref_addr = 2'd3; ref_f3 = F3_H;  #1 chk("la_h3", ref_data, 32'hFFFF_8899);
    ref_addr = 2'd2; ref_f3 = 3'b011; #1 chk("la_undef", ref_data, 32'h8899_AABB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
